rv_decode_stage: RTL

//  Registered RV32IM decode stage between fetch and execute in the 3-stage core.

---
 rtl/rv_decode_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_decode_stage.sv
// Registered RV32IM decode stage (csrrw-IO, lui, R-type incl. M, I-type ALU) between fetch and EX.
// Latency: 1 cycle from accept to out_valid; mul-class entries stall fetch for MUL_LAT-1 cycles after EX takes them.
// Backpressure: in_ready drops while the output register is held (out_valid && !out_ready) or during MUL_WAIT.
// Optional: define DECODE_ILLEGAL_CNT_EN to add a saturating illegal_cnt output.
module rv_decode_stage #(
  parameter int          NUM_IO  = 2,
  parameter logic [11:0] IO_BASE = 12'hF00,
  parameter int          MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  aluop,
  output logic        alusrc,
  output logic [1:0]  regsel,
  output logic        regwrite,
  output logic        gpio_we,
  output logic [2:0]  io_idx,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
`ifdef DECODE_ILLEGAL_CNT_EN
  output logic [15:0] illegal_cnt,
`endif
  output logic        illegal
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  localparam logic [12:0] NIO          = 13'(NUM_IO);
  localparam logic [2:0]  NIO3         = 3'(NUM_IO);
  localparam logic [3:0]  MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam bit          MUL_MULTI    = (MUL_LAT > 1);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [12:0] csr_off;
  logic        accept;
  logic        consume;
  logic        mul_q;

  logic [3:0]  d_aluop;
  logic        d_alusrc;
  logic [1:0]  d_regsel;
  logic        d_regwrite;
  logic        d_gpio_we;
  logic [2:0]  d_io_idx;
  logic [31:0] d_imm;
  logic        d_illegal;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  // 13-bit subtraction: addresses below IO_BASE wrap to a huge offset and fall outside both windows
  assign csr_off = {1'b0, instr[31:20]} - {1'b0, IO_BASE};
  assign accept  = in_valid && in_ready && !flush;
  assign consume = out_valid && out_ready && !flush;
  assign mul_q   = (aluop == ALU_MUL) || (aluop == ALU_MULH) || (aluop == ALU_MULHU);

  // Combinational decode of the incoming word; an unsupported encoding becomes a flagged bubble
  always_comb begin
    d_aluop    = ALU_AND;
    d_alusrc   = 1'b0;
    d_regsel   = 2'b00;
    d_regwrite = 1'b0;
    d_gpio_we  = 1'b0;
    d_io_idx   = 3'd0;
    d_imm      = {{20{instr[31]}}, instr[31:20]};
    d_illegal  = 1'b1;
    case (opcode)
      7'h73: begin
        if (funct3 == 3'b001) begin
          if (csr_off < NIO) begin
            d_regwrite = 1'b1;
            d_io_idx   = csr_off[2:0];
            d_illegal  = 1'b0;
          end else if (csr_off < (NIO << 1)) begin
            d_gpio_we = 1'b1;
            d_io_idx  = csr_off[2:0] - NIO3;
            d_illegal = 1'b0;
          end
        end
      end
      7'h37: begin
        d_regsel   = 2'b01;
        d_regwrite = 1'b1;
        d_imm      = {instr[31:12], 12'h000};
        d_illegal  = 1'b0;
      end
      7'h33: begin
        d_regsel   = 2'b10;
        d_regwrite = 1'b1;
        d_illegal  = 1'b0;
        case ({funct7, funct3})
          {7'h00, 3'b000}: d_aluop = ALU_ADD;
          {7'h00, 3'b001}: d_aluop = ALU_SLL;
          {7'h00, 3'b010}: d_aluop = ALU_SLT;
          {7'h00, 3'b011}: d_aluop = ALU_SLTU;
          {7'h00, 3'b100}: d_aluop = ALU_XOR;
          {7'h00, 3'b101}: d_aluop = ALU_SRL;
          {7'h00, 3'b110}: d_aluop = ALU_OR;
          {7'h00, 3'b111}: d_aluop = ALU_AND;
          {7'h20, 3'b000}: d_aluop = ALU_SUB;
          {7'h20, 3'b101}: d_aluop = ALU_SRA;
          {7'h01, 3'b000}: d_aluop = ALU_MUL;
          {7'h01, 3'b001}: d_aluop = ALU_MULH;
          {7'h01, 3'b011}: d_aluop = ALU_MULHU;
          default:         d_illegal = 1'b1;
        endcase
      end
      7'h13: begin
        d_alusrc   = 1'b1;
        d_regsel   = 2'b10;
        d_regwrite = 1'b1;
        d_illegal  = 1'b0;
        case (funct3)
          3'b000: d_aluop = ALU_ADD;
          3'b010: d_aluop = ALU_SLT;
          3'b011: d_aluop = ALU_SLTU;
          3'b100: d_aluop = ALU_XOR;
          3'b110: d_aluop = ALU_OR;
          3'b111: d_aluop = ALU_AND;
          3'b001: begin
            if (funct7 == 7'h00) d_aluop = ALU_SLL;
            else                 d_illegal = 1'b1;
          end
          default: begin
            if (funct7 == 7'h00)      d_aluop = ALU_SRL;
            else if (funct7 == 7'h20) d_aluop = ALU_SRA;
            else                      d_illegal = 1'b1;
          end
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
    // Illegal entries must not write anything downstream
    if (d_illegal) begin
      d_aluop    = ALU_AND;
      d_alusrc   = 1'b0;
      d_regsel   = 2'b00;
      d_regwrite = 1'b0;
      d_gpio_we  = 1'b0;
      d_io_idx   = 3'd0;
    end
  end

  // Output register: load on accept, hold while EX stalls, drop on consume or flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      aluop     <= 4'd0;
      alusrc    <= 1'b0;
      regsel    <= 2'b00;
      regwrite  <= 1'b0;
      gpio_we   <= 1'b0;
      io_idx    <= 3'd0;
      rd        <= 5'd0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      imm       <= 32'd0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      aluop     <= d_aluop;
      alusrc    <= d_alusrc;
      regsel    <= d_regsel;
      regwrite  <= d_regwrite;
      gpio_we   <= d_gpio_we;
      io_idx    <= d_io_idx;
      rd        <= instr[11:7];
      rs1       <= instr[19:15];
      rs2       <= instr[24:20];
      imm       <= d_imm;
      illegal   <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Multiply sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiply sequencer next state and fetch backpressure; flush overrides a pending mul handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MUL_MULTI && consume && mul_q) begin
            state_d = MUL_WAIT;
            cnt_d   = MUL_CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
    in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  end

`ifdef DECODE_ILLEGAL_CNT_EN
  // Saturating count of illegal entries actually taken by EX; survives flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= 16'd0;
    end else if (consume && illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule
